// File: rtl/float_pkg.sv
// Shared floating-point field layout, special-value constants and classification
// helpers for the float datapath blocks.
package float_pkg;

  localparam int DEFAULT_MANTISSA_SIZE = 23;
  localparam int DEFAULT_EXPONENT_SIZE = 8;

  localparam int MANTISSA_POS = 0;
  localparam int EXPONENT_POS = MANTISSA_POS + DEFAULT_MANTISSA_SIZE;
  localparam int SIGN_POS     = EXPONENT_POS + DEFAULT_EXPONENT_SIZE;
  localparam int BIAS         = 2 ** (DEFAULT_EXPONENT_SIZE - 1) - 1;

  localparam logic [DEFAULT_EXPONENT_SIZE-1:0] EXPONENT_INVALID_VALUE = '1;

  typedef struct packed {
    logic isZero;
    logic isInf;
    logic isNaN;
    logic isSubnormal;
  } floatClass_t;

  // Special-case outcome decided up front and carried alongside the datapath
  typedef struct packed {
    logic isNaNRes;
    logic isInfRes;
    logic infSign;
    logic negZero;
  } specials_t;

  function automatic floatClass_t classify(input logic expZero, input logic expOnes,
                                           input logic fracZero);
    floatClass_t c;
    c.isZero      = expZero & fracZero;
    c.isSubnormal = expZero & ~fracZero;
    c.isInf       = expOnes & fracZero;
    c.isNaN       = expOnes & ~fracZero;
    return c;
  endfunction

  // Positive quiet NaN: exponent all ones, fraction MSB set, rest zero
  function automatic logic [63:0] canonicalQNaN(input int mSize, input int eSize);
    logic [63:0] bits;
    bits = '0;
    for (int i = 0; i < eSize; i++) bits[mSize + i] = 1'b1;
    bits[mSize - 1] = 1'b1;
    return bits;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter; an all-zero value reports VALUE_SIZE.
module float_lzc #(
  parameter int VALUE_SIZE = 27,
  localparam int COUNT_W = $clog2(VALUE_SIZE) + 1
) (
  input  logic [VALUE_SIZE-1:0] value,
  output logic [COUNT_W-1:0]    count
);

  // Scanning upward lets the highest set bit have the final say
  always_comb begin
    count = COUNT_W'(VALUE_SIZE);
    for (int i = 0; i < VALUE_SIZE; i++) begin
      if (value[i]) count = COUNT_W'(VALUE_SIZE - 1 - i);
    end
  end

endmodule

// File: rtl/float_add_sub_pipe.sv
// Four-stage IEEE-754-style adder/subtractor with round-to-nearest-even,
// special-value handling and a single global stall driven by the output handshake.
module float_add_sub_pipe
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = DEFAULT_MANTISSA_SIZE,
  parameter int EXPONENT_SIZE = DEFAULT_EXPONENT_SIZE,
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOAT_SIZE-1:0] aIn,
  input  logic [FLOAT_SIZE-1:0] bIn,
  input  logic                  subtract,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [FLOAT_SIZE-1:0] result,
  output logic                  overflow,
  output logic                  invalid,
  output logic                  outValid,
  input  logic                  outReady
);

  localparam int SIG_W = MANTISSA_SIZE + 1;
  localparam int ALN_W = SIG_W + 3;
  localparam int SUM_W = ALN_W + 1;
  localparam int LZC_W = $clog2(ALN_W) + 1;
  localparam int EM_W  = EXPONENT_SIZE + MANTISSA_SIZE;
  localparam logic [FLOAT_SIZE-1:0] QNAN =
    FLOAT_SIZE'(canonicalQNaN(MANTISSA_SIZE, EXPONENT_SIZE));

  function automatic logic [EM_W:0] roundNearestEven(input logic [EXPONENT_SIZE:0] exp,
                                                     input logic [ALN_W-2:0] mant);
    logic up;
    up = mant[2] & (mant[1] | mant[0] | mant[3]);
    return {exp, mant[ALN_W-2:3]} + {{EM_W{1'b0}}, up};
  endfunction

  function automatic logic [FLOAT_SIZE-1:0] saturateInf(input logic sign);
    return {sign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
  endfunction

  logic advance;
  assign advance = !outValid || outReady;
  assign inReady = advance;

  logic vld_p1, vld_p2, vld_p3;

  // Stage 1: effective sign, magnitude ordering, significands, classification
  logic                     aSign, bSign, aBig;
  logic [EXPONENT_SIZE-1:0] aExp, bExp, aEff, bEff;
  logic [MANTISSA_SIZE-1:0] aFrac, bFrac;
  logic [SIG_W-1:0]         aSig, bSig;
  floatClass_t              aCls, bCls;
  specials_t                spec_p0;

  always_comb begin
    aSign = aIn[FLOAT_SIZE-1];
    bSign = bIn[FLOAT_SIZE-1] ^ subtract;
    aExp  = aIn[MANTISSA_SIZE +: EXPONENT_SIZE];
    bExp  = bIn[MANTISSA_SIZE +: EXPONENT_SIZE];
    aFrac = aIn[MANTISSA_SIZE-1:0];
    bFrac = bIn[MANTISSA_SIZE-1:0];
    aCls  = classify(aExp == '0, aExp == '1, aFrac == '0);
    bCls  = classify(bExp == '0, bExp == '1, bFrac == '0);
    aEff  = (aCls.isZero || aCls.isSubnormal) ? EXPONENT_SIZE'(1) : aExp;
    bEff  = (bCls.isZero || bCls.isSubnormal) ? EXPONENT_SIZE'(1) : bExp;
    aSig  = {!(aCls.isZero || aCls.isSubnormal), aFrac};
    bSig  = {!(bCls.isZero || bCls.isSubnormal), bFrac};
    aBig  = aIn[FLOAT_SIZE-2:0] >= bIn[FLOAT_SIZE-2:0];
    spec_p0.isNaNRes = aCls.isNaN | bCls.isNaN | (aCls.isInf & bCls.isInf & (aSign ^ bSign));
    spec_p0.isInfRes = aCls.isInf | bCls.isInf;
    spec_p0.infSign  = aCls.isInf ? aSign : bSign;
    spec_p0.negZero  = aCls.isZero & bCls.isZero & aSign & bSign;
  end

  logic                     bigSign_p1, effSub_p1;
  logic [EXPONENT_SIZE-1:0] bigExp_p1, expDiff_p1;
  logic [SIG_W-1:0]         bigSig_p1, smallSig_p1;
  specials_t                spec_p1;

  // Stage 2: align the smaller significand, folding shifted-out bits into sticky
  logic [ALN_W-1:0] smallExt, lostMask, smallAln;

  always_comb begin
    smallExt = {smallSig_p1, 3'b000};
    lostMask = '0;
    if ({{(32-EXPONENT_SIZE){1'b0}}, expDiff_p1} >= 32'(MANTISSA_SIZE + 3)) begin
      smallAln = {{(ALN_W-1){1'b0}}, |smallSig_p1};
    end else begin
      lostMask = (ALN_W'(1) << expDiff_p1) - ALN_W'(1);
      smallAln = (smallExt >> expDiff_p1) | {{(ALN_W-1){1'b0}}, |(smallExt & lostMask)};
    end
  end

  logic                     bigSign_p2, effSub_p2;
  logic [EXPONENT_SIZE-1:0] bigExp_p2;
  logic [ALN_W-1:0]         bigExt_p2, smallAln_p2;
  specials_t                spec_p2;

  // Stage 3: magnitude add/subtract; big >= small so the difference never goes negative
  logic [SUM_W-1:0] sumNext;
  logic [LZC_W-1:0] lzcNext;

  assign sumNext = effSub_p2 ? ({1'b0, bigExt_p2} - {1'b0, smallAln_p2})
                             : ({1'b0, bigExt_p2} + {1'b0, smallAln_p2});

  float_lzc #(.VALUE_SIZE(ALN_W)) u_lzc (
    .value(sumNext[ALN_W-1:0]),
    .count(lzcNext)
  );

  logic                     bigSign_p3;
  logic [EXPONENT_SIZE-1:0] bigExp_p3;
  logic [SUM_W-1:0]         sum_p3;
  logic [LZC_W-1:0]         lzc_p3;
  specials_t                spec_p3;

  // Stage 4: normalise, round, apply specials; left shift stops at exponent 1
  int                       shiftAmt;
  logic [ALN_W-1:0]         normMant;
  logic [EXPONENT_SIZE:0]   normExp;
  logic [EM_W:0]            rounded;
  logic [FLOAT_SIZE-1:0]    resNext;
  logic                     ovfNext, invNext;

  always_comb begin
    shiftAmt = 0;
    if (sum_p3[SUM_W-1]) begin
      normMant = {sum_p3[SUM_W-1:2], |sum_p3[1:0]};
      normExp  = {1'b0, bigExp_p3} + (EXPONENT_SIZE+1)'(1);
    end else begin
      shiftAmt = (int'(lzc_p3) < int'(bigExp_p3) - 1) ? int'(lzc_p3) : int'(bigExp_p3) - 1;
      normMant = sum_p3[ALN_W-1:0] << shiftAmt;
      normExp  = normMant[ALN_W-1] ? ({1'b0, bigExp_p3} - (EXPONENT_SIZE+1)'(shiftAmt)) : '0;
    end
    rounded = roundNearestEven(normExp, normMant[ALN_W-2:0]);
    ovfNext = 1'b0;
    invNext = 1'b0;
    if (spec_p3.isNaNRes) begin
      resNext = QNAN;
      invNext = 1'b1;
    end else if (spec_p3.isInfRes) begin
      resNext = saturateInf(spec_p3.infSign);
    end else if (sum_p3 == '0) begin
      resNext = {spec_p3.negZero, {(FLOAT_SIZE-1){1'b0}}};
    end else if (rounded[EM_W:MANTISSA_SIZE] >= {1'b0, {EXPONENT_SIZE{1'b1}}}) begin
      resNext = saturateInf(bigSign_p3);
      ovfNext = 1'b1;
    end else begin
      resNext = {bigSign_p3, rounded[EM_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      outValid <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (advance) begin
      vld_p1   <= inValid;
      vld_p2   <= vld_p1;
      vld_p3   <= vld_p2;
      outValid <= vld_p3;
      result   <= resNext;
      overflow <= vld_p3 & ovfNext;
      invalid  <= vld_p3 & invNext;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      bigSign_p1  <= aBig ? aSign : bSign;
      effSub_p1   <= aSign ^ bSign;
      bigExp_p1   <= aBig ? aEff : bEff;
      expDiff_p1  <= aBig ? (aEff - bEff) : (bEff - aEff);
      bigSig_p1   <= aBig ? aSig : bSig;
      smallSig_p1 <= aBig ? bSig : aSig;
      spec_p1     <= spec_p0;

      bigSign_p2  <= bigSign_p1;
      effSub_p2   <= effSub_p1;
      bigExp_p2   <= bigExp_p1;
      bigExt_p2   <= {bigSig_p1, 3'b000};
      smallAln_p2 <= smallAln;
      spec_p2     <= spec_p1;

      bigSign_p3  <= bigSign_p2;
      bigExp_p3   <= bigExp_p2;
      sum_p3      <= sumNext;
      lzc_p3      <= lzcNext;
      spec_p3     <= spec_p2;
    end
  end

endmodule
